// File: rtl/fpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_sequencer_if
// Purpose  : Core request channel plus the four FP-unit AXI-Stream channels.
// Revision : 1.0
// ============================================================================
interface fpu_sequencer_if;
    logic        REQ_VALID, REQ_READY;
    logic [2:0]  REQ_OP;
    logic [31:0] REQ_A, REQ_B;
    logic        BUSY, DONE, ERR;
    logic [31:0] RESULT;

    logic [31:0] ADDSUB_A_TDATA, ADDSUB_B_TDATA, ADDSUB_R_TDATA;
    logic        ADDSUB_A_TVALID, ADDSUB_B_TVALID, ADDSUB_A_TREADY, ADDSUB_B_TREADY;
    logic        ADDSUB_R_TVALID, ADDSUB_R_TREADY;
    logic [7:0]  ADDSUB_OP_TDATA;
    logic        ADDSUB_OP_TVALID, ADDSUB_OP_TREADY;

    logic [31:0] MUL_A_TDATA, MUL_B_TDATA, MUL_R_TDATA;
    logic        MUL_A_TVALID, MUL_B_TVALID, MUL_A_TREADY, MUL_B_TREADY;
    logic        MUL_R_TVALID, MUL_R_TREADY;

    logic [31:0] DIV_A_TDATA, DIV_B_TDATA, DIV_R_TDATA;
    logic        DIV_A_TVALID, DIV_B_TVALID, DIV_A_TREADY, DIV_B_TREADY;
    logic        DIV_R_TVALID, DIV_R_TREADY;

    logic [31:0] COMP_A_TDATA, COMP_B_TDATA, COMP_R_TDATA;
    logic        COMP_A_TVALID, COMP_B_TVALID, COMP_A_TREADY, COMP_B_TREADY;
    logic        COMP_R_TVALID, COMP_R_TREADY;
    logic [7:0]  COMP_OP_TDATA;
    logic        COMP_OP_TVALID, COMP_OP_TREADY;

    // master: the sequencer; slave: core and FP units
    modport master (
        input  REQ_VALID, REQ_OP, REQ_A, REQ_B,
        output REQ_READY, BUSY, DONE, ERR, RESULT,
        output ADDSUB_A_TDATA, ADDSUB_B_TDATA, ADDSUB_A_TVALID, ADDSUB_B_TVALID, ADDSUB_R_TREADY,
        output ADDSUB_OP_TDATA, ADDSUB_OP_TVALID,
        input  ADDSUB_A_TREADY, ADDSUB_B_TREADY, ADDSUB_R_TDATA, ADDSUB_R_TVALID, ADDSUB_OP_TREADY,
        output MUL_A_TDATA, MUL_B_TDATA, MUL_A_TVALID, MUL_B_TVALID, MUL_R_TREADY,
        input  MUL_A_TREADY, MUL_B_TREADY, MUL_R_TDATA, MUL_R_TVALID,
        output DIV_A_TDATA, DIV_B_TDATA, DIV_A_TVALID, DIV_B_TVALID, DIV_R_TREADY,
        input  DIV_A_TREADY, DIV_B_TREADY, DIV_R_TDATA, DIV_R_TVALID,
        output COMP_A_TDATA, COMP_B_TDATA, COMP_A_TVALID, COMP_B_TVALID, COMP_R_TREADY,
        output COMP_OP_TDATA, COMP_OP_TVALID,
        input  COMP_A_TREADY, COMP_B_TREADY, COMP_R_TDATA, COMP_R_TVALID, COMP_OP_TREADY
    );

    modport slave (
        output REQ_VALID, REQ_OP, REQ_A, REQ_B,
        input  REQ_READY, BUSY, DONE, ERR, RESULT,
        input  ADDSUB_A_TDATA, ADDSUB_B_TDATA, ADDSUB_A_TVALID, ADDSUB_B_TVALID, ADDSUB_R_TREADY,
        input  ADDSUB_OP_TDATA, ADDSUB_OP_TVALID,
        output ADDSUB_A_TREADY, ADDSUB_B_TREADY, ADDSUB_R_TDATA, ADDSUB_R_TVALID, ADDSUB_OP_TREADY,
        input  MUL_A_TDATA, MUL_B_TDATA, MUL_A_TVALID, MUL_B_TVALID, MUL_R_TREADY,
        output MUL_A_TREADY, MUL_B_TREADY, MUL_R_TDATA, MUL_R_TVALID,
        input  DIV_A_TDATA, DIV_B_TDATA, DIV_A_TVALID, DIV_B_TVALID, DIV_R_TREADY,
        output DIV_A_TREADY, DIV_B_TREADY, DIV_R_TDATA, DIV_R_TVALID,
        input  COMP_A_TDATA, COMP_B_TDATA, COMP_A_TVALID, COMP_B_TVALID, COMP_R_TREADY,
        input  COMP_OP_TDATA, COMP_OP_TVALID,
        output COMP_A_TREADY, COMP_B_TREADY, COMP_R_TDATA, COMP_R_TVALID, COMP_OP_TREADY
    );
endinterface
`default_nettype wire

// File: rtl/fpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_sequencer
// Purpose  : Issues one FP request to an AXI-Stream unit and returns its result.
// Revision : 1.0
// ============================================================================
module fpu_sequencer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    fpu_sequencer_if.master bus
);
    localparam int   CW      = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    localparam int   WD_LAST = (1 << CW) - 2;
    localparam logic WD_EN   = (TIMEOUT_W > 0);

    localparam logic [1:0] U_ADDSUB = 2'd0;
    localparam logic [1:0] U_MUL    = 2'd1;
    localparam logic [1:0] U_DIV    = 2'd2;
    localparam logic [1:0] U_COMP   = 2'd3;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_FLUSH} state_t;
    state_t state, state_nxt;

    function automatic logic [1:0] unit_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: unit_of = U_ADDSUB;
            3'd2:       unit_of = U_MUL;
            3'd3:       unit_of = U_DIV;
            default:    unit_of = U_COMP;
        endcase
    endfunction

    function automatic logic [7:0] opcode_of(input logic [2:0] op);
        case (op)
            3'd1:    opcode_of = 8'h01;
            3'd4:    opcode_of = 8'h14;
            3'd5:    opcode_of = 8'h0C;
            3'd6:    opcode_of = 8'h1C;
            default: opcode_of = 8'h00;
        endcase
    endfunction

    logic [2:0]    op_q;
    logic [31:0]   a_q, b_q, result;
    logic [7:0]    opc_q;
    logic          a_vld, b_vld, o_vld, a_sent, b_sent, o_sent;
    logic          r_rdy, done, err;
    logic [CW-1:0] wd_cnt;

    logic [1:0]    unit;
    logic          need_op, is_cmp, a_rdy, b_rdy, o_rdy, r_vld;
    logic [31:0]   r_data;
    logic          accept, issue_done, wd_fire, timeout, capture;

    assign unit    = unit_of(op_q);
    assign need_op = (unit == U_ADDSUB) || (unit == U_COMP);
    assign is_cmp  = (unit == U_COMP);

    always_comb begin
        a_rdy  = 1'b0;
        b_rdy  = 1'b0;
        o_rdy  = 1'b0;
        r_vld  = 1'b0;
        r_data = '0;
        case (unit)
            U_ADDSUB: begin
                a_rdy = bus.ADDSUB_A_TREADY; b_rdy = bus.ADDSUB_B_TREADY;
                o_rdy = bus.ADDSUB_OP_TREADY;
                r_vld = bus.ADDSUB_R_TVALID; r_data = bus.ADDSUB_R_TDATA;
            end
            U_MUL: begin
                a_rdy = bus.MUL_A_TREADY; b_rdy = bus.MUL_B_TREADY;
                r_vld = bus.MUL_R_TVALID; r_data = bus.MUL_R_TDATA;
            end
            U_DIV: begin
                a_rdy = bus.DIV_A_TREADY; b_rdy = bus.DIV_B_TREADY;
                r_vld = bus.DIV_R_TVALID; r_data = bus.DIV_R_TDATA;
            end
            default: begin
                a_rdy = bus.COMP_A_TREADY; b_rdy = bus.COMP_B_TREADY;
                o_rdy = bus.COMP_OP_TREADY;
                r_vld = bus.COMP_R_TVALID; r_data = bus.COMP_R_TDATA;
            end
        endcase
    end

    assign accept     = (state == S_IDLE) && bus.REQ_VALID;
    assign issue_done = (a_sent || (a_vld && a_rdy)) && (b_sent || (b_vld && b_rdy)) &&
                        (!need_op || o_sent || (o_vld && o_rdy));
    assign wd_fire    = WD_EN && (wd_cnt == WD_LAST[CW-1:0]);

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (bus.REQ_OP == OP_ILLEGAL) ? S_RESP : S_ISSUE;
            S_ISSUE: if (wd_fire) state_nxt = S_FLUSH;
                     else if (issue_done) state_nxt = S_WAIT;
            // a result arriving on the terminal cycle still wins over the abort
            S_WAIT:  if (r_vld) state_nxt = S_RESP;
                     else if (wd_fire) state_nxt = S_FLUSH;
            S_RESP:  state_nxt = S_IDLE;
            S_FLUSH: if (r_vld || wd_fire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign timeout = (state == S_ISSUE || state == S_WAIT) && (state_nxt == S_FLUSH);
    assign capture = (state == S_WAIT) && r_vld;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            op_q <= '0; a_q <= '0; b_q <= '0; opc_q <= '0;
            a_vld <= 1'b0; b_vld <= 1'b0; o_vld <= 1'b0;
            a_sent <= 1'b0; b_sent <= 1'b0; o_sent <= 1'b0;
            r_rdy <= 1'b0; done <= 1'b0; err <= 1'b0;
            result <= '0; wd_cnt <= '0;
        end else begin
            if (accept) op_q <= bus.REQ_OP;
            // operand and opcode data only live on the bus while issuing
            a_q   <= (state_nxt != S_ISSUE) ? '0 : (accept ? bus.REQ_A : a_q);
            b_q   <= (state_nxt != S_ISSUE) ? '0 : (accept ? bus.REQ_B : b_q);
            opc_q <= (state_nxt != S_ISSUE) ? '0 : (accept ? opcode_of(bus.REQ_OP) : opc_q);
            a_vld <= (state_nxt == S_ISSUE) && (accept || (a_vld && !a_rdy));
            b_vld <= (state_nxt == S_ISSUE) && (accept || (b_vld && !b_rdy));
            o_vld <= (state_nxt == S_ISSUE) &&
                     (accept ? (unit_of(bus.REQ_OP) == U_ADDSUB || unit_of(bus.REQ_OP) == U_COMP)
                             : (o_vld && !o_rdy));
            a_sent <= !accept && (a_sent || (a_vld && a_rdy));
            b_sent <= !accept && (b_sent || (b_vld && b_rdy));
            o_sent <= !accept && (o_sent || (o_vld && o_rdy));
            r_rdy  <= (state_nxt == S_WAIT) || (state_nxt == S_FLUSH);
            done   <= (state_nxt == S_RESP) || timeout;
            err    <= (accept && state_nxt == S_RESP) || timeout;

            if (accept || timeout)                          wd_cnt <= '0;
            else if (state == S_ISSUE || state == S_WAIT ||
                     state == S_FLUSH)                      wd_cnt <= wd_cnt + 1'b1;

            if (accept && state_nxt == S_RESP) result <= '0;
            else if (capture)                  result <= is_cmp ? {31'b0, r_data[0]} : r_data;
            else if (timeout)                  result <= is_cmp ? 32'h0 : 32'h7FC00000;
        end
    end

    assign bus.REQ_READY = (state == S_IDLE) && RST_N;
    assign bus.BUSY      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_FLUSH);
    assign bus.DONE      = done;
    assign bus.ERR       = err;
    assign bus.RESULT    = result;

    assign bus.ADDSUB_A_TVALID  = a_vld && (unit == U_ADDSUB);
    assign bus.ADDSUB_B_TVALID  = b_vld && (unit == U_ADDSUB);
    assign bus.ADDSUB_OP_TVALID = o_vld && (unit == U_ADDSUB);
    assign bus.ADDSUB_R_TREADY  = r_rdy && (unit == U_ADDSUB);
    assign bus.ADDSUB_A_TDATA   = (unit == U_ADDSUB) ? a_q : '0;
    assign bus.ADDSUB_B_TDATA   = (unit == U_ADDSUB) ? b_q : '0;
    assign bus.ADDSUB_OP_TDATA  = (unit == U_ADDSUB) ? opc_q : '0;

    assign bus.MUL_A_TVALID = a_vld && (unit == U_MUL);
    assign bus.MUL_B_TVALID = b_vld && (unit == U_MUL);
    assign bus.MUL_R_TREADY = r_rdy && (unit == U_MUL);
    assign bus.MUL_A_TDATA  = (unit == U_MUL) ? a_q : '0;
    assign bus.MUL_B_TDATA  = (unit == U_MUL) ? b_q : '0;

    assign bus.DIV_A_TVALID = a_vld && (unit == U_DIV);
    assign bus.DIV_B_TVALID = b_vld && (unit == U_DIV);
    assign bus.DIV_R_TREADY = r_rdy && (unit == U_DIV);
    assign bus.DIV_A_TDATA  = (unit == U_DIV) ? a_q : '0;
    assign bus.DIV_B_TDATA  = (unit == U_DIV) ? b_q : '0;

    assign bus.COMP_A_TVALID  = a_vld && (unit == U_COMP);
    assign bus.COMP_B_TVALID  = b_vld && (unit == U_COMP);
    assign bus.COMP_OP_TVALID = o_vld && (unit == U_COMP);
    assign bus.COMP_R_TREADY  = r_rdy && (unit == U_COMP);
    assign bus.COMP_A_TDATA   = (unit == U_COMP) ? a_q : '0;
    assign bus.COMP_B_TDATA   = (unit == U_COMP) ? b_q : '0;
    assign bus.COMP_OP_TDATA  = (unit == U_COMP) ? opc_q : '0;
endmodule
`default_nettype wire

// File: tb/tb_fpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_sequencer
// Purpose  : Directed self-checking bench for fpu_sequencer.
// Revision : 1.0
// ============================================================================
module tb_fpu_sequencer;
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    fpu_sequencer_if bus();

    fpu_sequencer #(.TIMEOUT_W(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    wire any_valid = bus.ADDSUB_A_TVALID | bus.ADDSUB_B_TVALID | bus.ADDSUB_OP_TVALID |
                     bus.MUL_A_TVALID | bus.MUL_B_TVALID | bus.DIV_A_TVALID | bus.DIV_B_TVALID |
                     bus.COMP_A_TVALID | bus.COMP_B_TVALID | bus.COMP_OP_TVALID;
    wire any_rready = bus.ADDSUB_R_TREADY | bus.MUL_R_TREADY | bus.DIV_R_TREADY | bus.COMP_R_TREADY;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.REQ_VALID = 1'b0; bus.REQ_OP = '0; bus.REQ_A = '0; bus.REQ_B = '0;
        bus.ADDSUB_A_TREADY = 1'b0; bus.ADDSUB_B_TREADY = 1'b0; bus.ADDSUB_OP_TREADY = 1'b0;
        bus.ADDSUB_R_TVALID = 1'b0; bus.ADDSUB_R_TDATA = '0;
        bus.MUL_A_TREADY = 1'b0; bus.MUL_B_TREADY = 1'b0; bus.MUL_R_TVALID = 1'b0; bus.MUL_R_TDATA = '0;
        bus.DIV_A_TREADY = 1'b0; bus.DIV_B_TREADY = 1'b0; bus.DIV_R_TVALID = 1'b0; bus.DIV_R_TDATA = '0;
        bus.COMP_A_TREADY = 1'b0; bus.COMP_B_TREADY = 1'b0; bus.COMP_OP_TREADY = 1'b0;
        bus.COMP_R_TVALID = 1'b0; bus.COMP_R_TDATA = '0;
    endtask

    // presents a request in an IDLE cycle; returns in the first ISSUE cycle
    task automatic request(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.REQ_VALID = 1'b1; bus.REQ_OP = op; bus.REQ_A = a; bus.REQ_B = b;
        step();
        bus.REQ_VALID = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        idle_inputs();
        RST_N = 1'b0;
        step(); step(); look();
        check("rst_req_ready", bus.REQ_READY, 0);
        check("rst_busy",      bus.BUSY, 0);
        check("rst_done_err",  {bus.DONE, bus.ERR}, 0);
        check("rst_result",    bus.RESULT, 0);
        check("rst_tvalid",    any_valid, 0);
        check("rst_rready",    any_rready, 0);
        check("rst_tdata",     bus.ADDSUB_A_TDATA | bus.COMP_B_TDATA | bus.MUL_A_TDATA, 0);
        step(); RST_N = 1'b1; look();
        check("ready_after_rst", bus.REQ_READY, 1);

        // fadd 1.0 + 2.0, result 2 cycles into WAIT
        bus.ADDSUB_A_TREADY = 1'b1; bus.ADDSUB_B_TREADY = 1'b1; bus.ADDSUB_OP_TREADY = 1'b1;
        request(3'd0, 32'h3F800000, 32'h40000000); look();
        check("add_valids",  {bus.ADDSUB_A_TVALID, bus.ADDSUB_B_TVALID, bus.ADDSUB_OP_TVALID}, 3'b111);
        check("add_opdata",  bus.ADDSUB_OP_TDATA, 8'h00);
        check("add_adata",   bus.ADDSUB_A_TDATA, 32'h3F800000);
        check("add_bdata",   bus.ADDSUB_B_TDATA, 32'h40000000);
        check("add_busy",    bus.BUSY, 1);
        check("add_other_unit", bus.MUL_A_TVALID | bus.COMP_A_TVALID | bus.DIV_A_TVALID, 0);
        check("add_no_ready_early", bus.REQ_READY, 0);
        step(); look();
        check("add_wait_rready", bus.ADDSUB_R_TREADY, 1);
        check("add_valid_drop",  any_valid, 0);
        check("add_tdata_clear", bus.ADDSUB_A_TDATA, 0);
        step(); look();
        check("add_done_k3", bus.DONE, 0);
        step(); bus.ADDSUB_R_TVALID = 1'b1; bus.ADDSUB_R_TDATA = 32'h40400000; look();
        check("add_done_k4", bus.DONE, 0);
        step(); bus.ADDSUB_R_TVALID = 1'b0; look();
        check("add_done_k5", bus.DONE, 1);
        check("add_result",  bus.RESULT, 32'h40400000);
        check("add_err",     bus.ERR, 0);
        check("add_busy_done", bus.BUSY, 0);
        step(); look();
        check("add_done_once", bus.DONE, 0);
        check("add_ready_back", bus.REQ_READY, 1);

        // fle 1.0 <= 1.0, twice with different raw unit results
        bus.COMP_A_TREADY = 1'b1; bus.COMP_B_TREADY = 1'b1; bus.COMP_OP_TREADY = 1'b1;
        request(3'd6, 32'h3F800000, 32'h3F800000); look();
        check("fle_opdata", bus.COMP_OP_TDATA, 8'h1C);
        check("fle_avalid", bus.COMP_A_TVALID, 1);
        check("fle_addsub_idle", bus.ADDSUB_A_TVALID | bus.ADDSUB_OP_TVALID, 0);
        check("fle_addsub_opdata", bus.ADDSUB_OP_TDATA, 0);
        step(); bus.COMP_R_TVALID = 1'b1; bus.COMP_R_TDATA = 32'h00000001;
        step(); bus.COMP_R_TVALID = 1'b0; look();
        check("fle_done",   bus.DONE, 1);
        check("fle_result1", bus.RESULT, 32'h00000001);
        step(); look();
        check("fle_result_hold", bus.RESULT, 32'h00000001);
        request(3'd6, 32'h3F800000, 32'h3F800000);
        step(); bus.COMP_R_TVALID = 1'b1; bus.COMP_R_TDATA = 32'hFFFFFFFE;
        step(); bus.COMP_R_TVALID = 1'b0; look();
        check("fle_done2",   bus.DONE, 1);
        check("fle_result0", bus.RESULT, 32'h00000000);
        step();

        // fmul 2.0 * 3.0 with B backpressure until k+4
        bus.MUL_A_TREADY = 1'b1; bus.MUL_B_TREADY = 1'b0;
        request(3'd2, 32'h40000000, 32'h40400000); look();
        check("mul_k1_valids", {bus.MUL_A_TVALID, bus.MUL_B_TVALID}, 2'b11);
        check("mul_bdata",     bus.MUL_B_TDATA, 32'h40400000);
        step(); look();
        check("mul_k2_valids", {bus.MUL_A_TVALID, bus.MUL_B_TVALID}, 2'b01);
        check("mul_k2_rready", bus.MUL_R_TREADY, 0);
        step(); look();
        check("mul_k3_bvalid", bus.MUL_B_TVALID, 1);
        step(); bus.MUL_B_TREADY = 1'b1; look();
        check("mul_k4_bvalid", bus.MUL_B_TVALID, 1);
        step(); bus.MUL_R_TVALID = 1'b1; bus.MUL_R_TDATA = 32'h40C00000; look();
        check("mul_k5_bvalid", bus.MUL_B_TVALID, 0);
        check("mul_k5_rready", bus.MUL_R_TREADY, 1);
        check("mul_k5_done",   bus.DONE, 0);
        step(); bus.MUL_R_TVALID = 1'b0; look();
        check("mul_done",   bus.DONE, 1);
        check("mul_result", bus.RESULT, 32'h40C00000);
        step(); look();
        check("mul_single_done", bus.DONE, 0);

        // illegal opcode
        request(3'd7, 32'h12345678, 32'h00000009); look();
        check("ill_done_err", {bus.DONE, bus.ERR}, 2'b11);
        check("ill_result",   bus.RESULT, 0);
        check("ill_tvalid",   any_valid, 0);
        check("ill_ready_k1", bus.REQ_READY, 0);
        check("ill_busy",     bus.BUSY, 0);
        step(); look();
        check("ill_ready_k2", bus.REQ_READY, 1);
        check("ill_pulse_end", {bus.DONE, bus.ERR}, 2'b00);

        // fdiv timeout with TIMEOUT_W=4, then a late beat flushed
        bus.DIV_A_TREADY = 1'b1; bus.DIV_B_TREADY = 1'b1;
        request(3'd3, 32'h3F800000, 32'h00000000);
        n = 1; look();
        while (!bus.DONE && n < 40) begin
            step(); n++; look();
        end
        check("to_latency", n, 16);
        check("to_err",     bus.ERR, 1);
        check("to_result",  bus.RESULT, 32'h7FC00000);
        check("to_busy",    bus.BUSY, 1);
        check("to_rready",  bus.DIV_R_TREADY, 1);
        check("to_tvalid",  any_valid, 0);
        step(); bus.DIV_R_TVALID = 1'b1; bus.DIV_R_TDATA = 32'h12345678; look();
        check("flush_no_done", bus.DONE, 0);
        check("flush_busy",    bus.BUSY, 1);
        step(); bus.DIV_R_TVALID = 1'b0; look();
        check("flush_idle",   bus.REQ_READY, 1);
        check("flush_busy_end", bus.BUSY, 0);
        check("flush_result_kept", bus.RESULT, 32'h7FC00000);

        // reset during WAIT, then fsub 3.0 - 1.0
        bus.ADDSUB_A_TREADY = 1'b1; bus.ADDSUB_B_TREADY = 1'b1; bus.ADDSUB_OP_TREADY = 1'b1;
        request(3'd1, 32'h40400000, 32'h3F800000);
        step(); RST_N = 1'b0; look();
        check("rw_in_wait", bus.ADDSUB_R_TREADY, 1);
        step(); RST_N = 1'b1; look();
        check("rw_done",   {bus.DONE, bus.ERR}, 0);
        check("rw_rready", any_rready, 0);
        check("rw_busy",   bus.BUSY, 0);
        check("rw_result", bus.RESULT, 0);
        check("rw_ready",  bus.REQ_READY, 1);
        request(3'd1, 32'h40400000, 32'h3F800000); look();
        check("sub_opdata", bus.ADDSUB_OP_TDATA, 8'h01);
        step(); bus.ADDSUB_R_TVALID = 1'b1; bus.ADDSUB_R_TDATA = 32'h40000000;
        step(); bus.ADDSUB_R_TVALID = 1'b0; look();
        check("sub_done",   {bus.DONE, bus.ERR}, 2'b10);
        check("sub_result", bus.RESULT, 32'h40000000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
